// File: rtl/alu_pkg.sv
// Shared types for the operator front-end: operation codes, sequencer states
// and the fixed-priority button arbiter.
package alu_pkg;

    localparam int NUM_BTN = 5;

    // Button index equals operation code: C=0, U=1, D=2, L=3, R=4.
    typedef enum logic [2:0] {
        OP_MULT = 3'd0,
        OP_LO   = 3'd1,
        OP_NO   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_REARM
    } state_t;

    // Lowest set index wins; scanning downwards lets the last hit be the winner.
    function automatic op_t pick_op(input logic [NUM_BTN-1:0] pulses);
        op_t sel;
        sel = OP_MULT;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pulses[i]) begin
                sel = op_t'(3'(i));
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer: one-cycle pulse when a press qualifies, plus a
// debounced level that only falls after a qualified release.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] hi_cnt_reg;
    logic [CW-1:0] lo_cnt_reg;
    logic          pulse_reg;
    logic          level_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_reg <= '0;
            lo_cnt_reg <= '0;
            pulse_reg  <= 1'b0;
            level_reg  <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            if (btn_in) begin
                lo_cnt_reg <= '0;
                // Saturating count means a held button pulses only once.
                if (hi_cnt_reg != CNT_MAX) begin
                    hi_cnt_reg <= hi_cnt_reg + 1'b1;
                    if (hi_cnt_reg == CNT_MAX - 1'b1) begin
                        pulse_reg <= 1'b1;
                        level_reg <= 1'b1;
                    end
                end
            end else begin
                hi_cnt_reg <= '0;
                if (lo_cnt_reg != CNT_MAX) begin
                    lo_cnt_reg <= lo_cnt_reg + 1'b1;
                    if (lo_cnt_reg == CNT_MAX - 1'b1) begin
                        level_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign pulse = pulse_reg;
    assign level = level_reg;

endmodule

// File: rtl/alu_op_sequencer.sv
// Button-driven command sequencer for the operator datapath: debounce,
// arbitrate, issue one command with valid/ready, and latch the result on LED.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] SW,
    input  logic            BTNC,
    input  logic            BTNU,
    input  logic            BTND,
    input  logic            BTNL,
    input  logic            BTNR,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [2:0]      op_sel,
    output logic [BITS-1:0] op_a,
    input  logic            res_valid,
    input  logic [BITS-1:0] res_data,
    output logic [BITS-1:0] LED,
    output logic            busy,
    output logic            timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] btn_pulse;
    logic [NUM_BTN-1:0] btn_level;

    assign raw_btn = {BTNR, BTNL, BTND, BTNU, BTNC};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .btn_in(raw_btn[gi]),
                .pulse (btn_pulse[gi]),
                .level (btn_level[gi])
            );
        end
    endgenerate

    state_t          state_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic            op_valid_reg;
    op_t             op_sel_reg;
    logic [BITS-1:0] op_a_reg;
    logic [BITS-1:0] led_reg;
    logic            busy_reg;
    logic            timeout_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            tmo_cnt_reg  <= '0;
            op_valid_reg <= 1'b0;
            op_sel_reg   <= OP_MULT;
            op_a_reg     <= '0;
            led_reg      <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|btn_pulse) begin
                        op_sel_reg   <= pick_op(btn_pulse);
                        op_a_reg     <= SW;
                        op_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        timeout_reg  <= 1'b0;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_ready) begin
                        op_valid_reg <= 1'b0;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result on the last allowed cycle wins over the abort.
                    if (res_valid) begin
                        led_reg   <= res_data;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_REARM;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        timeout_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_REARM;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_REARM: begin
                    if (!(|btn_level)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign op_valid = op_valid_reg;
    assign op_sel   = op_sel_reg;
    assign op_a     = op_a_reg;
    assign LED      = led_reg;
    assign busy     = busy_reg;
    assign timeout  = timeout_reg;

endmodule
